uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one UART Transmitter among NUM_REQ byte requesters using round-robin arbitration.
- Per byte: latches the winning requester's data, issues a one-cycle start pulse, then follows the Transmitter busy flag through the frame.
- Reports completion per byte, and flags an error if the Transmitter never asserts busy.
- Sits between the Transmitter and the TopModuleRs232-level client logic.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 8, byte width fed to the Transmitter Input.
- BUSY_TIMEOUT, 16, cycles allowed between tx_start and tx_busy rising before an error is declared.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  requester i has a byte pending; held until its req_ack.
- req_data  input  NUM_REQ*DATA_WIDTH  byte of requester i in bits [i*8 +: 8].
- req_ack  output  NUM_REQ  one-cycle pulse; the byte of requester i has been captured.
- tx_busy  input  1  Transmitter TxD_busy.
- tx_start  output  1  one-cycle launch pulse to the Transmitter.
- tx_data  output  DATA_WIDTH  byte driven to the Transmitter Input; stable from tx_start until done.
- grant_id  output  3  index of the current or last granted requester.
- tx_done  output  1  one-cycle pulse; the granted byte has fully left the Transmitter.
- error  output  1  one-cycle pulse on busy timeout.
- active  output  1  high in every state except IDLE.

Behaviour:
- Reset, sampled at the rising edge of Clk, sets:
  - state=IDLE;
  - req_ack, tx_start, tx_done, error, active = 0;
  - tx_data=0, grant_id=0;
  - rr pointer=NUM_REQ-1, so requester 0 wins first;
  - timeout counter=0.
- Reset mid-frame aborts tracking immediately. No ack or done is issued for the aborted byte.
- All outputs are registered.
- State IDLE:
  - Arbitrates only if tx_busy==0 and any req_valid is set.
  - Winner w is the first set req_valid scanning from (ptr+1) mod NUM_REQ upward, with wrap-around.
  - Next edge: tx_data<=req_data[w], grant_id<=w, ptr<=w, req_ack[w]<=1, tx_start<=1, counter<=0, state<=WAIT_BUSY.
  - Arbitration is latency 1 from sampled request to ack/start.
- State WAIT_BUSY:
  - tx_start and req_ack return to 0.
  - If tx_busy==1, go to WAIT_DONE.
  - Otherwise the counter increments. When counter reaches BUSY_TIMEOUT-1 with tx_busy still 0: error<=1 for one cycle, state<=IDLE, no tx_done.
  - The rr pointer still advances past the failed requester.
- State WAIT_DONE:
  - When tx_busy==0: tx_done<=1 for one cycle, state<=IDLE.
  - The next grant can occur in the following IDLE cycle, so the minimum gap between tx_done and the next tx_start is 1 cycle.
- Requester rules:
  - A requester drops req_valid, or presents a new byte, in the cycle after it sees req_ack.
  - req_valid seen while the arbiter is not in IDLE is ignored; no ack.
  - Requests never drop: a requester whose valid stays high is served within NUM_REQ grants.
- Simultaneous events:
  - tx_busy falling in the same cycle that new requests arrive: tx_done first, new grant next cycle.
  - tx_busy rising on the exact timeout cycle: busy wins, no error.
- Single requester continuously valid: served back-to-back, each grant separated by a full frame plus 1 idle cycle.

Decomposition:
- Shared package uart_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_WAIT_BUSY=2'd1, ST_WAIT_DONE=2'd2;
  - UART_DATA_WIDTH=8.
- Sub-module rr_picker: purely combinational round-robin select. Inputs req vector and ptr; outputs winner index and any_valid.
- The FSM, data/grant registers and timeout counter stay in uart_tx_arbiter.

Test Plan:
- Reset held 3 cycles then released, no requests -> all outputs 0, active=0, no tx_start.
- Only req_valid[2]=1 with data 8'hA5, Transmitter model raising busy 2 cycles after start and holding it 10 cycles -> sequence:
  - req_ack[2] and tx_start at cycle+1;
  - tx_data=8'hA5 and grant_id=2;
  - tx_done one cycle after busy falls.
- All four requesters valid continuously -> grant order 0,1,2,3,0 with data matching each index; tx_data is never altered while busy.
- Transmitter model never asserts busy -> error pulses exactly BUSY_TIMEOUT cycles after tx_start; no tx_done; arbiter back in IDLE; next grant goes to the next index.
- Reset asserted mid-WAIT_DONE -> next cycle all outputs 0, no tx_done; after release the first grant goes to requester 0.
- req_valid[1] raised while in WAIT_DONE and tx_busy falls in the same cycle -> tx_done, then tx_start with grant_id=1 on the following edge.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding and data width.
package uart_pkg;

  localparam int unsigned UART_DATA_WIDTH = 8;
  localparam int unsigned GRANT_W         = 3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_WAIT_DONE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin select: first set request scanning upward from ptr+1, with wrap.
module rr_picker
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [GRANT_W-1:0] ptr_i,
  output logic [GRANT_W-1:0] winner_o,
  output logic               any_valid_o
);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [2*NUM_REQ-1:0] req_rot;
  logic                 found;
  int unsigned          shamt;

  // Rotate so bit 0 of req_rot is requester (ptr+1) mod NUM_REQ, then take the lowest set bit.
  always_comb begin
    shamt    = (32'(ptr_i) + 32'd1) % NUM_REQ;
    req_dbl  = {req_i, req_i};
    req_rot  = req_dbl >> shamt;
    winner_o = '0;
    found    = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!found && req_rot[k]) begin
        found    = 1'b1;
        winner_o = GRANT_W'((shamt + k) % NUM_REQ);
      end
    end
  end

  assign any_valid_o = |req_i;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte requesters;
// tracks the transmitter busy flag per byte and flags a busy timeout.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned DATA_WIDTH   = UART_DATA_WIDTH,
  parameter int unsigned BUSY_TIMEOUT = 16
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ack,
  input  logic                          tx_busy,
  output logic                          tx_start,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic [GRANT_W-1:0]            grant_id,
  output logic                          tx_done,
  output logic                          error,
  output logic                          active
);

  localparam int unsigned     CntW    = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(BUSY_TIMEOUT - 1);

  arb_state_e          state_q, state_d;
  logic [GRANT_W-1:0]  ptr_q, ptr_d;
  logic [GRANT_W-1:0]  grant_q, grant_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic [NUM_REQ-1:0]  req_ack_q, req_ack_d;
  logic                tx_start_q, tx_start_d;
  logic                tx_done_q, tx_done_d;
  logic                error_q, error_d;
  logic                active_q, active_d;

  logic [GRANT_W-1:0]    pick_winner;
  logic                  pick_any;
  logic [DATA_WIDTH-1:0] pick_data;

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_picker (
    .req_i       (req_valid),
    .ptr_i       (ptr_q),
    .winner_o    (pick_winner),
    .any_valid_o (pick_any)
  );

  always_comb begin
    pick_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_winner == GRANT_W'(i)) begin
        pick_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    cnt_d      = cnt_q;
    tx_data_d  = tx_data_q;
    req_ack_d  = '0;
    tx_start_d = 1'b0;
    tx_done_d  = 1'b0;
    error_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!tx_busy && pick_any) begin
          tx_data_d  = pick_data;
          grant_d    = pick_winner;
          ptr_d      = pick_winner;
          req_ack_d  = NUM_REQ'(1) << pick_winner;
          tx_start_d = 1'b1;
          cnt_d      = '0;
          state_d    = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        // Busy takes priority over the timeout on the final counted cycle.
        if (tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (cnt_q == CntLast) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) begin
          tx_done_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    active_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= GRANT_W'(NUM_REQ - 1);
      grant_q    <= '0;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      req_ack_q  <= '0;
      tx_start_q <= 1'b0;
      tx_done_q  <= 1'b0;
      error_q    <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      req_ack_q  <= req_ack_d;
      tx_start_q <= tx_start_d;
      tx_done_q  <= tx_done_d;
      error_q    <= error_d;
      active_q   <= active_d;
    end
  end

  assign req_ack  = req_ack_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign grant_id = grant_q;
  assign tx_done  = tx_done_q;
  assign error    = error_q;
  assign active   = active_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: per-cycle transaction model, table of arbitration
// vectors, directed corner sequences and a randomized run against a transmitter model.
module tb_uart_tx_arbiter;

  localparam int unsigned NUM_REQ      = 4;
  localparam int unsigned DW           = 8;
  localparam int unsigned BUSY_TIMEOUT = 16;

  logic                     Clk = 1'b0;
  logic                     Reset = 1'b1;
  logic [NUM_REQ-1:0]       req_valid = '0;
  logic [NUM_REQ*DW-1:0]    req_data;
  logic [NUM_REQ-1:0]       req_ack;
  logic                     tx_busy = 1'b0;
  logic                     tx_start;
  logic [DW-1:0]            tx_data;
  logic [2:0]               grant_id;
  logic                     tx_done;
  logic                     error;
  logic                     active;
  logic [DW-1:0]            rdata [NUM_REQ];

  always #5 Clk = ~Clk;

  always_comb begin
    req_data = '0;
    for (int i = 0; i < NUM_REQ; i++) req_data[i*DW +: DW] = rdata[i];
  end

  uart_tx_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .DATA_WIDTH   (DW),
    .BUSY_TIMEOUT (BUSY_TIMEOUT)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ack   (req_ack),
    .tx_busy   (tx_busy),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .grant_id  (grant_id),
    .tx_done   (tx_done),
    .error     (error),
    .active    (active)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state: one byte in flight at a time.
  bit       in_frame = 0;
  bit       seen_busy = 0;
  int       wait_cnt = 0;
  int       m_ptr = NUM_REQ - 1;
  int       m_grant = 0;
  logic [7:0] m_data = '0;

  int start_cnt = 0, done_cnt = 0, err_cnt = 0;
  int last_start_cyc = 0, last_done_cyc = 0, last_err_cyc = 0;

  // Transmitter model and stimulus controls.
  int tx_phase = 0, tx_cnt = 0;
  int tx_delay = 1, tx_len = 2;
  bit tx_never = 0, rand_tx = 0, auto_req = 0, hold_reqs = 0, raise1_on_fall = 0;
  bit fell_now = 0;
  int fall_cyc = 0;

  typedef struct {
    logic [NUM_REQ-1:0] mask;
    int                 exp_grant;
    logic [7:0]         exp_data;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int rr_expect(input logic [NUM_REQ-1:0] v, input int ptr);
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = (ptr + k) % NUM_REQ;
      if (1'(v >> idx)) return idx;
    end
    return -1;
  endfunction

  task automatic check_cycle();
    int w;
    logic exp_start, exp_done, exp_err;
    logic [NUM_REQ-1:0] exp_ack;
    cyc++;
    if (Reset) begin
      chk("reset_outputs", 32'({req_ack, tx_start, tx_done, error, active, grant_id, tx_data}), 0);
      in_frame = 0;
      m_ptr = NUM_REQ - 1;
      m_grant = 0;
      m_data = '0;
      return;
    end
    exp_start = 0; exp_done = 0; exp_err = 0; w = m_grant;
    if (in_frame) begin
      if (seen_busy) begin
        if (!tx_busy) exp_done = 1;
      end else if (tx_busy) begin
        seen_busy = 1;
      end else begin
        wait_cnt++;
        if (wait_cnt == BUSY_TIMEOUT) exp_err = 1;
      end
    end else if (!tx_busy && |req_valid) begin
      exp_start = 1;
      w = rr_expect(req_valid, m_ptr);
    end
    if (exp_done || exp_err) in_frame = 0;
    if (exp_start) begin
      in_frame = 1; seen_busy = 0; wait_cnt = 0;
      m_ptr = w; m_grant = w; m_data = rdata[w];
    end
    exp_ack = exp_start ? (NUM_REQ'(1) << w) : '0;
    chk("tx_start", 32'(tx_start), 32'(exp_start));
    chk("tx_done", 32'(tx_done), 32'(exp_done));
    chk("error", 32'(error), 32'(exp_err));
    chk("req_ack", 32'(req_ack), 32'(exp_ack));
    chk("active", 32'(active), 32'(in_frame));
    chk("grant_id", 32'(grant_id), 32'(m_grant));
    chk("tx_data", 32'(tx_data), 32'(m_data));
    if (tx_start) begin start_cnt++; last_start_cyc = cyc; end
    if (tx_done) begin done_cnt++; last_done_cyc = cyc; end
    if (error) begin err_cnt++; last_err_cyc = cyc; end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ack[i]) begin
        if ($urandom_range(0, 1) == 0) req_valid[i] = 1'b0;
        else rdata[i] = 8'($urandom);
      end else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
        req_valid[i] = 1'b1;
        rdata[i] = 8'($urandom);
      end
    end
  endtask

  task automatic tx_model();
    int r;
    fell_now = 0;
    case (tx_phase)
      0: if (tx_start) begin
        if (rand_tx) begin
          r = $urandom_range(0, 15);
          tx_never = (r == 0);
          tx_delay = (r == 1) ? 15 : (r == 2) ? 16 : $urandom_range(0, 3);
          tx_len = $urandom_range(1, 6);
        end
        if (!tx_never) begin
          if (tx_delay == 0) begin tx_busy = 1; tx_cnt = tx_len; tx_phase = 2; end
          else begin tx_cnt = tx_delay; tx_phase = 1; end
        end
      end
      1: begin
        tx_cnt--;
        if (tx_cnt == 0) begin tx_busy = 1; tx_cnt = tx_len; tx_phase = 2; end
      end
      default: begin
        tx_cnt--;
        if (tx_cnt == 0) begin tx_busy = 0; tx_phase = 0; fell_now = 1; fall_cyc = cyc; end
      end
    endcase
  endtask

  task automatic step();
    @(negedge Clk);
    check_cycle();
    if (auto_req) drive_reqs();
    else if (!hold_reqs) req_valid = req_valid & ~req_ack;
    tx_model();
    if (raise1_on_fall && fell_now) begin
      req_valid[1] = 1'b1;
      rdata[1] = 8'h5C;
      raise1_on_fall = 0;
    end
  endtask

  // kind: 0 start, 1 done, 2 error, 3 model idle with transmitter quiet
  task automatic wait_for(input int kind, input int bound, input string name);
    bit hit;
    hit = 0;
    for (int n = 0; n < bound && !hit; n++) begin
      step();
      case (kind)
        0: hit = tx_start;
        1: hit = tx_done;
        2: hit = error;
        default: hit = !in_frame && !tx_busy;
      endcase
    end
    if (!hit) begin
      checks++; errors++;
      $display("FAIL %s: event not seen within %0d cycles", name, bound);
    end
  endtask

  task automatic do_reset();
    Reset = 1;
    repeat (2) step();
    Reset = 0;
  endtask

  initial begin
    int s, dc, ec;
    for (int i = 0; i < NUM_REQ; i++) rdata[i] = '0;
    tbl[0]  = '{4'b1111, 0, 8'hC0};
    tbl[1]  = '{4'b1111, 1, 8'hC1};
    tbl[2]  = '{4'b0001, 0, 8'hC0};
    tbl[3]  = '{4'b1000, 3, 8'hC3};
    tbl[4]  = '{4'b1001, 0, 8'hC0};
    tbl[5]  = '{4'b0110, 1, 8'hC1};
    tbl[6]  = '{4'b0110, 2, 8'hC2};
    tbl[7]  = '{4'b1010, 3, 8'hC3};
    tbl[8]  = '{4'b0101, 0, 8'hC0};
    tbl[9]  = '{4'b0101, 2, 8'hC2};
    tbl[10] = '{4'b0011, 0, 8'hC0};
    tbl[11] = '{4'b1100, 2, 8'hC2};

    // Reset for three cycles, then quiet.
    repeat (3) step();
    Reset = 0;
    repeat (4) step();
    chk("idle_no_start", 32'(start_cnt), 0);
    chk("idle_active", 32'(active), 0);

    // Single requester 2.
    tx_delay = 2; tx_len = 10;
    rdata[2] = 8'hA5; req_valid = 4'b0100;
    step();
    chk("single_start", 32'(tx_start), 1);
    chk("single_ack", 32'(req_ack), 32'h4);
    chk("single_data", 32'(tx_data), 32'hA5);
    chk("single_grant", 32'(grant_id), 2);
    wait_for(1, 40, "single_done");
    chk("done_after_fall", 32'(last_done_cyc), 32'(fall_cyc + 1));

    // All four continuously valid: 0,1,2,3,0.
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) rdata[i] = 8'h30 + 8'(i);
    tx_delay = 1; tx_len = 3; hold_reqs = 1; req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      wait_for(0, 40, "rr_start");
      chk("rr_order", 32'(grant_id), 32'(k % NUM_REQ));
      chk("rr_data", 32'(tx_data), 32'(8'h30 + 8'(k % NUM_REQ)));
      if (k > 0) chk("rr_gap", 32'(last_start_cyc - last_done_cyc), 1);
    end
    req_valid = '0;
    wait_for(3, 40, "rr_idle");

    // Transmitter never goes busy: timeout, then next index.
    tx_never = 1; req_valid = 4'hF;
    wait_for(0, 10, "to_start");
    chk("to_grant", 32'(grant_id), 1);
    s = last_start_cyc; dc = done_cnt;
    wait_for(2, 40, "to_error");
    chk("to_latency", 32'(last_err_cyc - s), BUSY_TIMEOUT);
    chk("to_no_done", 32'(done_cnt), 32'(dc));
    tx_never = 0;
    step();
    chk("to_next_grant", 32'(grant_id), 2);
    hold_reqs = 0; req_valid = '0;
    wait_for(3, 40, "to_idle");

    // Busy rising on the last counted cycle wins; one cycle later times out.
    tx_delay = 15; tx_len = 2; req_valid = 4'b0001; ec = err_cnt;
    wait_for(1, 40, "edge_done");
    chk("edge_no_error", 32'(err_cnt), 32'(ec));
    tx_delay = 16; req_valid = 4'b0001;
    wait_for(2, 40, "late_error");
    wait_for(3, 40, "late_idle");

    // Reset while waiting for the frame to finish.
    tx_delay = 1; tx_len = 8; req_valid = 4'b0100;
    wait_for(0, 10, "mid_start");
    repeat (4) step();
    Reset = 1;
    step();
    chk("mid_rst_active", 32'(active), 0);
    chk("mid_rst_done", 32'(tx_done), 0);
    Reset = 0; dc = done_cnt; req_valid = 4'b0101;
    wait_for(0, 30, "post_rst_start");
    chk("post_rst_grant", 32'(grant_id), 0);
    chk("post_rst_no_done", 32'(done_cnt), 32'(dc));
    req_valid = '0;
    wait_for(3, 40, "post_rst_idle");

    // Request raised in the same cycle busy falls.
    tx_delay = 1; tx_len = 3; req_valid = 4'b1000;
    wait_for(0, 10, "fall_start");
    raise1_on_fall = 1;
    wait_for(1, 20, "fall_done");
    step();
    chk("fall_next_start", 32'(tx_start), 1);
    chk("fall_next_grant", 32'(grant_id), 1);
    chk("fall_next_data", 32'(tx_data), 32'h5C);
    wait_for(3, 40, "fall_idle");

    // Table of arbitration vectors from a fresh reset.
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) rdata[i] = 8'hC0 + 8'(i);
    tx_delay = 0; tx_len = 1;
    foreach (tbl[t]) begin
      wait_for(3, 40, "tbl_idle");
      req_valid = tbl[t].mask;
      wait_for(0, 4, "tbl_start");
      chk("tbl_grant", 32'(grant_id), 32'(tbl[t].exp_grant));
      chk("tbl_data", 32'(tx_data), 32'(tbl[t].exp_data));
      req_valid = '0;
    end
    wait_for(3, 40, "tbl_end_idle");

    // Randomized traffic against the model.
    auto_req = 1; rand_tx = 1;
    repeat (4000) step();
    auto_req = 0; rand_tx = 0; tx_never = 0; req_valid = '0;
    wait_for(3, 100, "rand_drain");
    chk("rand_traffic_seen", 32'(start_cnt > 100), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
